// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the single-port RAM request controller.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_RESP  = 2'd2
    } ram_ctrl_state_e;

    // Address check against a position count that need not be a power of two.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned npos);
        return addr < npos;
    endfunction

endpackage

// File: rtl/ram_req_ctrl.sv
// Initiator side of a single-port RAM: valid/ready requests in, RAM cycles out,
// read responses back; optional zero-fill of every position after reset.
module ram_req_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NPos         = 1024,
    parameter bit          ClearOnReset = 1'b1,
    localparam int unsigned NPosWidth   = (NPos > 1) ? $clog2(NPos) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [NPosWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 init_done_o,
    output logic [NPosWidth-1:0] ram_a_o,
    output logic                 ram_we_o,
    output logic [DataWidth-1:0] ram_wd_o,
    input  logic [DataWidth-1:0] ram_rd_i
);

    localparam logic [NPosWidth-1:0] LastPos = NPosWidth'(NPos - 1);

    ram_ctrl_state_e      r_state;
    logic [NPosWidth-1:0] r_clr_cnt;
    logic                 r_rsp_valid;
    logic [DataWidth-1:0] r_rsp_rdata;
    logic                 r_init_done;

    logic w_in_range;
    logic w_ready;
    logic w_accept_rd;

    assign w_in_range  = addr_in_range(32'(req_addr_i), NPos);
    assign w_ready     = !rst_i && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready_i));
    assign w_accept_rd = w_ready && req_valid_i && !req_we_i;

    assign req_ready_o = w_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign init_done_o = r_init_done;

    // RAM port: clear sweep, or a pass-through of the request whenever it can be accepted.
    always_comb begin
        ram_a_o  = req_addr_i;
        ram_wd_o = req_wdata_i;
        ram_we_o = 1'b0;
        if (!rst_i && (r_state == S_CLEAR)) begin
            ram_a_o  = r_clr_cnt;
            ram_wd_o = '0;
            ram_we_o = 1'b1;
        end else if (w_ready) begin
            ram_we_o = req_valid_i && req_we_i && w_in_range;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ClearOnReset ? S_CLEAR : S_IDLE;
            r_clr_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_init_done <= !ClearOnReset;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_cnt == LastPos) begin
                        r_clr_cnt   <= '0;
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + NPosWidth'(1);
                    end
                end
                S_IDLE, S_RESP: begin
                    // A response handshake and a new accept share the same cycle.
                    if (w_accept_rd) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_in_range ? ram_rd_i : '0;
                        r_state     <= S_RESP;
                    end else if (w_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
